// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register-bank CPU access path.
// Holds the FSM encoding, register index map and default bank geometry.
package uart_reg_pkg;

  localparam int unsigned DEF_REG_WIDTH  = 32;
  localparam int unsigned DEF_NUM_REGS   = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_STATUS = 1;
  localparam int unsigned REG_TXDATA = 2;
  localparam int unsigned REG_RXDATA = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } reg_if_state_e;

endpackage

// File: rtl/uart_reg_addr_dec.sv
// Combinational word-address decoder: one-hot write/read strobes plus an
// out-of-range flag for addresses beyond the populated bank.
module uart_reg_addr_dec
  import uart_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  input  logic                  i_en,
  output logic [NUM_REGS-1:0]   o_wr_en,
  output logic [NUM_REGS-1:0]   o_rd_en,
  output logic                  o_out_of_range
);

  always_comb begin
    o_wr_en        = '0;
    o_rd_en        = '0;
    o_out_of_range = (32'(i_addr) >= NUM_REGS);
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (i_en && (i_addr == ADDR_WIDTH'(k))) begin
        o_wr_en[k] = i_write;
        o_rd_en[k] = !i_write;
      end
    end
  end

endmodule

// File: rtl/uart_reg_if.sv
// CPU-side access controller for the UART register bank (IDLE/ACCESS/RESP).
// Define UART_REG_IF_ERR_RESP_EN to flag out-of-range accesses on rsp_err_o.
module uart_reg_if
  import uart_reg_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_write_i,
  input  logic [ADDR_WIDTH-1:0]         req_addr_i,
  input  logic [REG_WIDTH-1:0]          req_wdata_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [REG_WIDTH-1:0]          rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic [NUM_REGS-1:0]           reg_wr_en_o,
  output logic [NUM_REGS-1:0]           reg_rd_en_o,
  output logic [REG_WIDTH-1:0]          reg_wdata_o,
  input  logic [NUM_REGS*REG_WIDTH-1:0] reg_rdata_i
);

  reg_if_state_e r_state;
  reg_if_state_e w_state_nxt;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_oor;

  logic                  w_accept;
  logic [NUM_REGS-1:0]   w_dec_wr;
  logic [NUM_REGS-1:0]   w_dec_rd;
  logic                  w_dec_oor;
  logic [REG_WIDTH-1:0]  w_sel_rdata;

  logic                  w_req_ready_nxt;
  logic                  w_rsp_valid_nxt;
  logic [REG_WIDTH-1:0]  w_rsp_rdata_nxt;
  logic                  w_rsp_err_nxt;
  logic [NUM_REGS-1:0]   w_wr_en_nxt;
  logic [NUM_REGS-1:0]   w_rd_en_nxt;
  logic [REG_WIDTH-1:0]  w_wdata_nxt;

  assign w_accept = (r_state == ST_IDLE) && req_valid_i && req_ready_o;

  // Strobes are decoded from the live request so they are registered into ACCESS.
  uart_reg_addr_dec #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_dec (
    .i_addr         (req_addr_i),
    .i_write        (req_write_i),
    .i_en           (w_accept),
    .o_wr_en        (w_dec_wr),
    .o_rd_en        (w_dec_rd),
    .o_out_of_range (w_dec_oor)
  );

  always_comb begin
    w_sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (r_addr == ADDR_WIDTH'(k)) begin
        w_sel_rdata = reg_rdata_i[k*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_oor   <= 1'b0;
    end else if (w_accept) begin
      r_write <= req_write_i;
      r_addr  <= req_addr_i;
      r_oor   <= w_dec_oor;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = req_ready_o;
    w_rsp_valid_nxt = rsp_valid_o;
    w_rsp_rdata_nxt = rsp_rdata_o;
    w_rsp_err_nxt   = rsp_err_o;
    w_wr_en_nxt     = '0;
    w_rd_en_nxt     = '0;
    w_wdata_nxt     = reg_wdata_o;
    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt     = ST_ACCESS;
          w_req_ready_nxt = 1'b0;
          w_wr_en_nxt     = w_dec_wr;
          w_rd_en_nxt     = w_dec_rd;
          if (req_write_i) begin
            w_wdata_nxt = req_wdata_i;
          end
        end
      end
      ST_ACCESS: begin
        // Read data is sampled on the same edge a read-clear register clears.
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = (!r_write && !r_oor) ? w_sel_rdata : '0;
`ifdef UART_REG_IF_ERR_RESP_EN
        w_rsp_err_nxt   = r_oor;
`else
        w_rsp_err_nxt   = 1'b0;
`endif
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_rsp_valid_nxt = 1'b0;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      reg_wr_en_o <= '0;
      reg_rd_en_o <= '0;
      reg_wdata_o <= '0;
    end else begin
      req_ready_o <= w_req_ready_nxt;
      rsp_valid_o <= w_rsp_valid_nxt;
      rsp_rdata_o <= w_rsp_rdata_nxt;
      rsp_err_o   <= w_rsp_err_nxt;
      reg_wr_en_o <= w_wr_en_nxt;
      reg_rd_en_o <= w_rd_en_nxt;
      reg_wdata_o <= w_wdata_nxt;
    end
  end

endmodule

// File: doc/uart_reg_if.md
Name: uart_reg_if

Overview:
CPU-side access controller for the UART register bank. It accepts single-beat read/write requests over a valid/ready request channel and decodes the word address. For each accepted request it drives exactly one single-cycle per-register write or read strobe. It captures read data and returns it over a valid/ready response channel. It is the initiator of the per-register CPU write-enable, read-enable and data signals consumed by each register instance.

Parameters:
- REG_WIDTH, 32, data width of each register and of the bus
- NUM_REGS, 4, number of registers in the bank; must be at least 1
- ADDR_WIDTH, 4, request word-address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  word address (register index)
- req_wdata_i  in  REG_WIDTH  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rdata_o  out  REG_WIDTH  read data
- rsp_err_o  out  1  access error
- reg_wr_en_o  out  NUM_REGS  one-hot CPU write strobe per register
- reg_rd_en_o  out  NUM_REGS  one-hot CPU read strobe per register
- reg_wdata_o  out  REG_WIDTH  write data broadcast to all registers
- reg_rdata_i  in  NUM_REGS*REG_WIDTH  flattened register outputs; register k occupies bits [k*REG_WIDTH +: REG_WIDTH]

Behaviour:
- Reset is asynchronous and active-low. While rst_ni = 0:
  - FSM is in IDLE.
  - req_ready_o = 1.
  - rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0.
  - reg_wr_en_o = 0, reg_rd_en_o = 0, reg_wdata_o = 0.
- Reset mid-transaction aborts the transaction immediately: strobes drop asynchronously and no response is produced.
- All outputs are registered. The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o at edge N: latch write, addr and wdata; go to ACCESS.
  - The request is not accepted while req_valid_i = 0.
- ACCESS (cycle N+1, exactly one cycle):
  - If addr < NUM_REGS and write: reg_wr_en_o[addr] = 1.
  - If addr < NUM_REGS and read: reg_rd_en_o[addr] = 1.
  - reg_wdata_o holds the latched wdata. It holds its value outside writes and is never cleared after reset.
  - For a read, rsp_rdata_o captures reg_rdata_i slice [addr] at the N+1 -> N+2 edge. This is the same edge at which a read-clear register clears, so the returned value is the pre-clear value.
  - For writes, rsp_rdata_o = 0.
  - Go to RESP.
- RESP (from N+2):
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o are held stable.
  - req_ready_o = 0.
  - On rsp_ready_i go to IDLE, deasserting rsp_valid_o on the next cycle.
  - rsp_ready_i may be held high permanently.
- Throughput:
  - Minimum latency from accepted request to rsp_valid_o is 2 cycles.
  - Back-to-back peak is one transaction per 3 cycles.
  - A request presented during ACCESS/RESP waits; req_valid_i must stay asserted and req_* must stay stable until accepted.
- Out-of-range address (addr >= NUM_REGS):
  - No strobe is asserted.
  - rsp_rdata_o = 0.
  - Response still completes with normal timing.
- At most one bit of reg_wr_en_o | reg_rd_en_o is ever set, and only in ACCESS.
- req_ready_o and rsp_valid_o are never both 1.

Optional Feature:
- Macro: UART_REG_IF_ERR_RESP_EN
- Defined: rsp_err_o = 1 in RESP for out-of-range addresses, else 0.
- Undefined: rsp_err_o is tied to 0 and out-of-range accesses are silently ignored (reads return 0).

Decomposition:
- Shared package uart_reg_pkg contains:
  - FSM state encoding typedef (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2).
  - Register index constants (e.g. REG_CTRL = 0, REG_STATUS = 1, REG_TXDATA = 2, REG_RXDATA = 3).
  - Default NUM_REGS and REG_WIDTH.
- One sub-module is natural: uart_reg_addr_dec.
  - Purely combinational.
  - Maps addr, write and an access-phase enable to the one-hot wr/rd strobe vectors and an out_of_range flag.
  - Registered by the parent.

Test Plan:
- Reset-release check: hold rst_ni = 0 for 3 cycles, then release → all outputs at reset values; req_ready_o = 1.
- Single write:
  - Stimulus: write addr 2, wdata 0xA5A5_0001.
  - Response: reg_wr_en_o = 4'b0100 for exactly one cycle with reg_wdata_o = 0xA5A5_0001; rsp_valid_o 2 cycles after acceptance; rsp_rdata_o = 0; rsp_err_o = 0.
- Read-clear read:
  - Stimulus: read addr 1 while reg_rdata_i slice 1 = 0x0000_0081, and the bank clears it on rd_en.
  - Response: reg_rd_en_o = 4'b0010 for one cycle; rsp_rdata_o = 0x0000_0081.
  - Follow-up: a second read returns 0.
- Response backpressure:
  - Stimulus: hold rsp_ready_i = 0 for 5 cycles during a read of addr 0.
  - Response: rsp_valid_o and rsp_rdata_o stay stable; req_ready_o = 0; a queued request is accepted only after the response handshake.
- Out-of-range:
  - Stimulus: read addr 7 with NUM_REGS = 4.
  - Response: no strobes; rsp_rdata_o = 0; rsp_err_o = 1 with UART_REG_IF_ERR_RESP_EN, 0 without.
- Mid-transaction reset:
  - Stimulus: assert rst_ni = 0 asynchronously during ACCESS of a write.
  - Response: reg_wr_en_o falls before the next clock edge; no rsp_valid_o after release; the next request completes normally.
